// File: rtl/ysyx_041514_fetch_ctrl.sv
// rtl/ysyx_041514_fetch_ctrl.sv - single-outstanding icache fetch sequencer with redirect kill
module ysyx_041514_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              clint_valid_i,
    input  logic [ADDR_W-1:0] clint_pc_i,
    output logic              if_req_o,
    output logic [ADDR_W-1:0] if_addr_o,
    input  logic              if_ready_i,
    input  logic              if_rvalid_i,
    input  logic [31:0]       if_rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              id_ready_i,
    output logic              pc_stall_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              kill_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] ipc_q;
    logic [15:0]       drop_cnt_q;

    logic              redir;
    logic [ADDR_W-1:0] redir_pc;

    // Trap wins over branch when both fire in the same cycle.
    assign redir    = clint_valid_i | branch_valid_i;
    assign redir_pc = clint_valid_i ? clint_pc_i : branch_pc_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_PC;
            kill_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            inst_q     <= '0;
            ipc_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    addr_q  <= RESET_PC;
                end
                S_REQ: begin
                    if (if_ready_i) begin
                        state_q <= S_WAIT;
                        if (redir) begin
                            kill_q    <= 1'b1;
                            pend_q    <= 1'b1;
                            pend_pc_q <= redir_pc;
                        end
                    end else if (redir) begin
                        addr_q <= redir_pc;
                    end
                end
                S_WAIT: begin
                    if (if_rvalid_i) begin
                        // A same-cycle redirect both kills the response and supplies the new target.
                        if (kill_q || redir) begin
                            if (drop_cnt_q != 16'hFFFF) begin
                                drop_cnt_q <= drop_cnt_q + 16'd1;
                            end
                            state_q <= S_REQ;
                            addr_q  <= redir ? redir_pc : (pend_q ? pend_pc_q : addr_q);
                            kill_q  <= 1'b0;
                            pend_q  <= 1'b0;
                        end else begin
                            inst_q  <= if_rdata_i;
                            ipc_q   <= addr_q;
                            state_q <= S_HOLD;
                        end
                    end else if (redir) begin
                        kill_q    <= 1'b1;
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_pc;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        state_q <= S_REQ;
                        addr_q  <= redir_pc;
                    end else if (id_ready_i) begin
                        state_q <= S_REQ;
                        addr_q  <= fetch_pc_i;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_req_o     = (state_q == S_REQ);
    assign if_addr_o    = addr_q;
    assign inst_valid_o = (state_q == S_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = ipc_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign pc_stall_o   = ~(((state_q == S_HOLD) & id_ready_i) | redir);

endmodule

// File: doc/ysyx_041514_fetch_ctrl.md
# ysyx_041514_fetch_ctrl

Fetch sequencer between the PC register and the instruction cache. It issues one icache read per instruction and arbitrates redirects (trap over branch) against in-flight fetches. It kills stale responses and drives the PC register's stall so the PC advances only when an instruction is handed to decode or a redirect is taken. Non-pipelined: at most one outstanding icache request.

## Interface
- `ADDR_W`, 32, fetch address width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fetch_pc_i`  in  ADDR_W  sequential next address from PC register (its `pc_next_o`)
- `branch_valid_i`  in  1  branch redirect pulse (EXE)
- `branch_pc_i`  in  ADDR_W  branch target
- `clint_valid_i`  in  1  trap redirect pulse (MEM), priority over branch
- `clint_pc_i`  in  ADDR_W  trap target
- `if_req_o`  out  1  icache read request
- `if_addr_o`  out  ADDR_W  icache read address
- `if_ready_i`  in  1  icache accepts request this cycle
- `if_rvalid_i`  in  1  icache read data valid (one pulse per accepted request)
- `if_rdata_i`  in  32  instruction word
- `inst_valid_o`  out  1  instruction available to decode
- `inst_o`  out  32  instruction
- `inst_pc_o`  out  ADDR_W  address of `inst_o`
- `id_ready_i`  in  1  decode accepts instruction
- `pc_stall_o`  out  1  stall to PC register (`stall_valid_i[PC]`)
- `drop_cnt_o`  out  16  saturating count of killed responses

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `addr_q`, `kill_q`, `pend_q`, `pend_pc_q`, `inst_q`, `ipc_q`, `drop_cnt_q`.
- Redirect arbitration: `redir = clint_valid_i | branch_valid_i`; `redir_pc = clint_valid_i ? clint_pc_i : branch_pc_i`.
- IDLE: entered only on reset. Next cycle → REQ with `addr_q = RESET_PC`.
- REQ: `if_req_o=1`, `if_addr_o=addr_q`.
  - `if_ready_i & ~redir` → WAIT.
  - `if_ready_i & redir` → WAIT, `kill_q=1`, `pend_pc_q=redir_pc`, `pend_q=1`.
  - `~if_ready_i & redir` → stay REQ, `addr_q=redir_pc`. Retargeting an unaccepted request is legal.
- WAIT: `if_req_o=0`.
  - A redirect sets `kill_q=1`, `pend_q=1` and `pend_pc_q=redir_pc`. A later redirect overwrites the pending target.
  - `if_rvalid_i` with kill (`kill_q` or a same-cycle `redir`): data dropped, `drop_cnt` incremented, → REQ with `addr_q` = pending target (the same-cycle redir wins), `kill_q=pend_q=0`.
  - `if_rvalid_i` without kill: `inst_q=if_rdata_i`, `ipc_q=addr_q`, → HOLD.
- HOLD: `inst_valid_o=1`.
  - `redir` → drop held inst (not counted), → REQ with `addr_q=redir_pc`.
  - else `id_ready_i` → REQ with `addr_q=fetch_pc_i`.
  - else stay.
- `pc_stall_o = ~((state==HOLD & id_ready_i) | redir)`. The PC register takes the branch/trap target itself on redirect cycles.
- `drop_cnt_o` saturates at 16'hFFFF.

## Timing
- Reset (asynchronous assert, synchronous-to-clk effect on release), all values forced:
  - state=IDLE
  - `if_req_o=0`, `if_addr_o=RESET_PC`
  - `inst_valid_o=0`, `inst_o=0`, `inst_pc_o=0`
  - `pc_stall_o=1`, `drop_cnt_o=0`
  - `kill_q=pend_q=0`
- Reset mid-WAIT: a response arriving after release is ignored, because state is IDLE/REQ and `if_rvalid_i` is only sampled in WAIT.
- `if_req_o` high from the first cycle after the IDLE cycle.
- Request handshake = `if_req_o & if_ready_i`. Response arrives ≥1 cycle after acceptance.
- `inst_valid_o` rises the cycle after `if_rvalid_i`. It is held with `inst_o`/`inst_pc_o` stable until `id_ready_i` or a redirect.
- Best case: 3 cycles per instruction (REQ, WAIT with rvalid, HOLD with `id_ready_i`).
- `if_rvalid_i` outside WAIT is a protocol violation; the block ignores it.
- All outputs are registered except `pc_stall_o` (combinational from state, `id_ready_i`, redirect inputs).

## Test plan
- Reset release, `if_ready_i=1`, rvalid 1 cycle after accept with 32'h00000413 → `if_addr_o=0x80000000` on cycle 2. `inst_valid_o` with `inst_pc_o=0x80000000`, `inst_o=0x00000413`. With `id_ready_i=1`: `pc_stall_o=0` that cycle, next `if_addr_o=fetch_pc_i` (0x80000004).
- `id_ready_i=0` for 5 cycles in HOLD → `inst_valid_o`, `inst_o` stable, `pc_stall_o=1`, no `if_req_o`.
- Branch to 0x80000100 during WAIT, response 2 cycles later → data dropped, `drop_cnt_o=1`, next request addr 0x80000100, `inst_valid_o` stays 0.
- `clint_valid_i` (0x80000800) and `branch_valid_i` (0x80000100) in the same cycle in HOLD → held inst dropped, next `if_addr_o=0x80000800`, `pc_stall_o=0` that cycle.
- Branch on the same cycle as `if_rvalid_i` → data dropped, REQ to branch target the next cycle, `drop_cnt_o` +1.
- `rst` asserted during WAIT, stale `if_rvalid_i` after release → ignored; fetch restarts at 0x80000000, `drop_cnt_o=0`.
